// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet RX framing path.
//   rx_state_t    : receive framer FSM states
//   PREAMBLE_BYTE : GMII preamble octet (0x55)
//   SFD_BYTE      : start-of-frame delimiter octet (0xD5)
//   FCS_LEN       : number of trailing FCS octets stripped from each frame
//   LEN_W         : width of the saturating frame length counter
// ---------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        CHECK    = 3'd3,
        DROP     = 3'd4
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         FCS_LEN       = 4;
    localparam int         LEN_W         = 11;

endpackage

// File: rtl/eth_rx_fcs_strip.sv
// ---------------------------------------------------------------------------
// eth_rx_fcs_strip
// Delay line that holds back the last FCS_LEN+1 bytes of a frame so the FCS
// can be dropped once the end of the frame is known.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : a new frame byte is available on data_i
//   flush_i    : end of frame; release the oldest held byte as the last beat
//   clear_i    : start of a new frame; forget any held bytes
//   data_i     : incoming frame byte
//   beat_o     : data_o is a payload byte to be emitted this cycle
//   last_o     : that payload byte is the final one of the frame
//   data_o     : oldest held byte
// ---------------------------------------------------------------------------
module eth_rx_fcs_strip
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       flush_i,
    input  logic       clear_i,
    input  logic [7:0] data_i,
    output logic       beat_o,
    output logic       last_o,
    output logic [7:0] data_o
);

    localparam int         DEPTH = FCS_LEN + 1;
    localparam logic [2:0] FULL  = 3'(DEPTH);

    logic [7:0] shift_q [DEPTH];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       full;

    assign full = (count_q == FULL);

    // A byte only leaves the line once it is known not to be FCS: either a
    // further byte pushes in behind a full line, or the frame ends while the
    // line is full. With fewer than DEPTH bytes held, everything is FCS (or
    // shorter) and nothing is released.
    assign beat_o = full && (push_i || flush_i);
    assign last_o = full && flush_i;
    assign data_o = shift_q[DEPTH-1];

    // Occupancy tracks how many real frame bytes sit in the line and stops
    // at DEPTH; both the start and the end of a frame empty it.
    always_comb begin
        count_d = count_q;
        if (clear_i || flush_i) begin
            count_d = '0;
        end else if (push_i && !full) begin
            count_d = count_q + 3'd1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Plain shift register: newest byte enters at index 0, so when the line
    // is full the oldest byte always sits at the far end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                shift_q[i] <= '0;
            end
        end else if (push_i) begin
            shift_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                shift_q[i] <= shift_q[i-1];
            end
        end
    end

endmodule

// File: rtl/eth_rx_frame.sv
// ---------------------------------------------------------------------------
// eth_rx_frame
// GMII receive framer. Strips preamble/SFD, streams frame bytes (including
// FCS) to an external CRC32 checker, strips the FCS and presents the payload
// as a byte stream with end-of-frame and error flags.
//   MIN_LEN, MAX_LEN : legal frame length range, DA through FCS
//   clk, rst_n       : clock, asynchronous active-low reset
//   rx_dv/rx_er/rxd  : GMII receive inputs
//   crc_valid        : byte strobe to the CRC checker
//   crc_data         : byte to the CRC checker
//   crc_clr_n        : active-low one-cycle checker init pulse at SFD
//   crc_ok           : checker result, valid in the cycle after the last byte
//   m_tdata/m_tvalid : payload byte stream
//   m_tlast/m_tuser  : last payload beat, frame-bad flag on that beat
//   stat_good        : pulse with a good m_tlast
//   stat_bad         : pulse with a bad m_tlast or a frame too short to emit
// ---------------------------------------------------------------------------
module eth_rx_frame
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic [7:0] rxd,
    output logic       crc_valid,
    output logic [7:0] crc_data,
    output logic       crc_clr_n,
    input  logic       crc_ok,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       stat_good,
    output logic       stat_bad
);

    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = '1;

    logic             dv_q;
    logic             er_q;
    logic [7:0]       rxd_q;

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             err_q;
    logic             err_d;

    logic             sfd_hit;
    logic             push;
    logic             flush;
    logic             frame_bad;

    logic             beat;
    logic             beat_last;
    logic [7:0]       beat_data;

    // Input register stage: everything downstream works on these copies so
    // the GMII pins see a single flop load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
            rxd_q <= '0;
        end else begin
            dv_q  <= rx_dv;
            er_q  <= rx_er;
            rxd_q <= rxd;
        end
    end

    // Framer state machine. A frame must open with at least one preamble
    // byte; anything unexpected before the SFD parks us in DROP until the
    // carrier goes away. CHECK lasts exactly one cycle and always returns to
    // IDLE, so a byte arriving during it (short IPG) is lost and the next
    // frame has to present a fresh preamble.
    always_comb begin
        state_d = state_q;
        sfd_hit = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dv_q) begin
                    state_d = (rxd_q == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == SFD_BYTE) begin
                    state_d = DATA;
                    sfd_hit = 1'b1;
                end else if (rxd_q != PREAMBLE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (dv_q) begin
                    push = 1'b1;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                flush   = 1'b1;
                state_d = IDLE;
            end
            DROP: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Length counter and sticky error. Oversize is flagged as soon as the
    // byte that crosses MAX_LEN arrives, so saturation of the counter later
    // on cannot hide it. Both are reset at the SFD.
    always_comb begin
        len_d = len_q;
        err_d = err_q;
        if (sfd_hit) begin
            len_d = '0;
            err_d = 1'b0;
        end else if (push) begin
            if (len_q != LEN_SAT) begin
                len_d = len_q + 1'b1;
            end
            if (er_q || (len_q >= MAX_LEN_C)) begin
                err_d = 1'b1;
            end
        end
    end

    // Final verdict, only meaningful in CHECK where crc_ok reflects the last
    // FCS byte.
    assign frame_bad = err_q || (len_q < MIN_LEN_C) || !crc_ok;

    // FSM, length and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    eth_rx_fcs_strip u_strip (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .flush_i (flush),
        .clear_i (sfd_hit),
        .data_i  (rxd_q),
        .beat_o  (beat),
        .last_o  (beat_last),
        .data_o  (beat_data)
    );

    // CRC checker feed. The init pulse lands in the cycle between the SFD
    // and the first DA byte, so the checker starts every frame from a clean
    // state even when frames are back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_valid <= 1'b0;
            crc_data  <= '0;
            crc_clr_n <= 1'b1;
        end else begin
            crc_valid <= push;
            crc_clr_n <= !sfd_hit;
            if (push) begin
                crc_data <= rxd_q;
            end
        end
    end

    // Payload and statistics outputs. A frame of FCS_LEN bytes or fewer
    // produces no beats but still reports stat_bad, since it is always a
    // runt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
            stat_good <= 1'b0;
            stat_bad  <= 1'b0;
        end else begin
            m_tvalid  <= beat;
            m_tlast   <= beat_last;
            m_tuser   <= beat_last && frame_bad;
            stat_good <= flush && !frame_bad;
            stat_bad  <= flush && frame_bad;
            if (beat) begin
                m_tdata <= beat_data;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_frame
// Self-checking bench for eth_rx_frame. A behavioural CRC32 checker closes
// the loop on crc_valid/crc_data/crc_clr_n and drives crc_ok back. Frames are
// described by a table of records with their expected outcomes; a few
// hand-written sequences cover back-to-back frames, short IPG and reset in
// the middle of a frame.
// ---------------------------------------------------------------------------
module tb_eth_rx_frame;

    typedef struct {
        int len;
        int badFcs;
        int erAt;
        int badPreAt;
        int expBeats;
        int expLast;
        int expTuser;
        int expGood;
        int expBad;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       crc_valid;
    logic [7:0] crc_data;
    logic       crc_clr_n;
    logic       crc_ok;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tuser;
    logic       stat_good;
    logic       stat_bad;

    int nChecks = 0;
    int nFail = 0;
    int cyc = 0;

    int beatTotal = 0;
    int lastTotal = 0;
    int tuserTotal = 0;
    int goodTotal = 0;
    int badTotal = 0;
    int clrTotal = 0;
    int tlastCyc = 0;
    int clrCyc = 0;
    int validCyc = 0;
    logic prevValid = 1'b0;
    logic [7:0] gotData[$];
    logic [7:0] sentData[$];

    logic [31:0] crcReg;

    vec_t vecs[12];

    eth_rx_frame #(
        .MIN_LEN (64),
        .MAX_LEN (1518)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .rxd       (rxd),
        .crc_valid (crc_valid),
        .crc_data  (crc_data),
        .crc_clr_n (crc_clr_n),
        .crc_ok    (crc_ok),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
    );

    // 100 MHz clock and a free-running cycle counter used to measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
    end

    // Reflected CRC-32 (IEEE 802.3) byte update, no final inversion.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Behavioural checker as wired at the RX top: init on crc_clr_n AND
    // rst_n, and report ok when the residue over data plus FCS is the
    // standard magic value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crcReg <= 32'hFFFF_FFFF;
        end else if (!crc_clr_n) begin
            crcReg <= 32'hFFFF_FFFF;
        end else if (crc_valid) begin
            crcReg <= crcByte(crcReg, crc_data);
        end
    end

    assign crc_ok = (crcReg == 32'hDEBB_20E3);

    // Output monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (m_tvalid) begin
            beatTotal++;
            gotData.push_back(m_tdata);
            if (m_tlast) begin
                lastTotal++;
                tlastCyc = cyc;
                if (m_tuser) begin
                    tuserTotal++;
                end
            end
        end
        if (stat_good) begin
            goodTotal++;
        end
        if (stat_bad) begin
            badTotal++;
        end
        if (!crc_clr_n) begin
            clrTotal++;
            clrCyc = cyc;
        end
        if (crc_valid && !prevValid) begin
            validCyc = cyc;
        end
        prevValid = crc_valid;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // All registered outputs packed together; only crc_clr_n idles high.
    task automatic checkResetOutputs(input string name);
        int packed_outs;
        packed_outs = int'({crc_clr_n, crc_valid, crc_data, m_tdata,
                            m_tvalid, m_tlast, m_tuser, stat_good, stat_bad});
        checkOutput(name, packed_outs, 32'h0040_0000);
    endtask

    // Drives 7 preamble bytes, SFD, then len frame bytes (data + FCS) and
    // ipg idle cycles. abortAt >= 0 asserts reset instead of that frame byte.
    task automatic sendFrame(input int len, input int badFcs, input int erAt,
                             input int badPreAt, input int abortAt, input int ipg,
                             output int sfdCyc, output int eCyc);
        logic [7:0]  fb[$];
        logic [31:0] c;
        logic [7:0]  b;
        fb = {};
        sentData = {};
        c = 32'hFFFF_FFFF;
        sfdCyc = 0;
        eCyc = 0;
        for (int i = 0; i < len - 4; i++) begin
            b = 8'(i * 13 + len);
            fb.push_back(b);
            sentData.push_back(b);
            c = crcByte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            b = c[8*k +: 8];
            if (badFcs != 0 && k == 3) begin
                b = b ^ 8'h01;
            end
            fb.push_back(b);
        end
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rx_er = 1'b0;
            rxd = (p == badPreAt) ? 8'h54 : 8'h55;
        end
        @(negedge clk);
        rxd = 8'hD5;
        sfdCyc = cyc;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == abortAt) begin
                rst_n = 1'b0;
                rx_dv = 1'b0;
                rx_er = 1'b0;
                rxd = 8'h00;
                return;
            end
            rx_dv = 1'b1;
            rx_er = (i == erAt) ? 1'b1 : 1'b0;
            rxd = fb[i];
            eCyc = cyc;
        end
        for (int g = 0; g < ipg; g++) begin
            @(negedge clk);
            rx_dv = 1'b0;
            rx_er = 1'b0;
            rxd = 8'h00;
        end
    endtask

    // Sends one table entry and compares everything it should have produced.
    task automatic applyStimulus(input vec_t v, input int idx);
        int b0, l0, t0, g0, bd0, c0, d0, sfdCyc, eCyc, mism;
        string tag;
        tag = $sformatf("vec%0d_len%0d", idx, v.len);
        b0 = beatTotal; l0 = lastTotal; t0 = tuserTotal;
        g0 = goodTotal; bd0 = badTotal; c0 = clrTotal; d0 = gotData.size();
        sendFrame(v.len, v.badFcs, v.erAt, v.badPreAt, -1, 12, sfdCyc, eCyc);
        checkOutput({tag, "_beats"}, beatTotal - b0, v.expBeats);
        checkOutput({tag, "_tlast"}, lastTotal - l0, v.expLast);
        checkOutput({tag, "_tuser"}, tuserTotal - t0, v.expTuser);
        checkOutput({tag, "_good"}, goodTotal - g0, v.expGood);
        if (v.expBad >= 0) begin
            checkOutput({tag, "_bad"}, badTotal - bd0, v.expBad);
        end
        checkOutput({tag, "_clrPulses"}, clrTotal - c0, (v.badPreAt >= 0) ? 0 : 1);
        if (v.badPreAt < 0) begin
            checkOutput({tag, "_clrLatency"}, clrCyc - sfdCyc, 2);
            checkOutput({tag, "_validLatency"}, validCyc - sfdCyc, 3);
        end
        if (v.expLast != 0) begin
            checkOutput({tag, "_tlastLatency"}, tlastCyc - eCyc, 4);
        end
        if (v.expBeats > 0) begin
            mism = 0;
            for (int k = 0; k < v.expBeats; k++) begin
                if (d0 + k >= gotData.size() || gotData[d0 + k] != sentData[k]) begin
                    mism++;
                end
            end
            checkOutput({tag, "_payloadMismatches"}, mism, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b0, g0, bd0, l0, t0, sfdCyc, eCyc;

        //          len  bad er  pre beats last tuser good bad
        vecs[0]  = '{64,   0, -1, -1,   60, 1, 0, 1, 0};
        vecs[1]  = '{64,   1, -1, -1,   60, 1, 1, 0, 1};
        vecs[2]  = '{40,   0, -1, -1,   36, 1, 1, 0, 1};
        vecs[3]  = '{1600, 0, -1, -1, 1596, 1, 1, 0, 1};
        vecs[4]  = '{64,   0, 10, -1,   60, 1, 1, 0, 1};
        vecs[5]  = '{64,   0, -1,  3,    0, 0, 0, 0, -1};
        vecs[6]  = '{63,   0, -1, -1,   59, 1, 1, 0, 1};
        vecs[7]  = '{5,    0, -1, -1,    1, 1, 1, 0, 1};
        vecs[8]  = '{4,    0, -1, -1,    0, 0, 0, 0, 1};
        vecs[9]  = '{1518, 0, -1, -1, 1514, 1, 0, 1, 0};
        vecs[10] = '{1519, 0, -1, -1, 1515, 1, 1, 0, 1};
        vecs[11] = '{65,   0, -1, -1,   61, 1, 0, 1, 0};

        $display("[TB] starting eth_rx_frame test");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("resetValues");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Two good frames with a standard 12-byte gap: the checker must be
        // re-initialised for the second one.
        b0 = beatTotal; g0 = goodTotal; bd0 = badTotal; t0 = tuserTotal;
        sendFrame(64, 0, -1, -1, -1, 12, sfdCyc, eCyc);
        sendFrame(64, 0, -1, -1, -1, 12, sfdCyc, eCyc);
        checkOutput("backToBack_beats", beatTotal - b0, 120);
        checkOutput("backToBack_good", goodTotal - g0, 2);
        checkOutput("backToBack_bad", badTotal - bd0, 0);
        checkOutput("backToBack_tuser", tuserTotal - t0, 0);

        // One-cycle gap: the first preamble byte of the next frame falls into
        // CHECK and is lost, the remaining six still frame it correctly.
        b0 = beatTotal; g0 = goodTotal; bd0 = badTotal;
        sendFrame(64, 0, -1, -1, -1, 1, sfdCyc, eCyc);
        sendFrame(64, 0, -1, -1, -1, 12, sfdCyc, eCyc);
        checkOutput("shortIpg_beats", beatTotal - b0, 120);
        checkOutput("shortIpg_good", goodTotal - g0, 2);
        checkOutput("shortIpg_bad", badTotal - bd0, 0);

        // Reset in the middle of a frame: outputs return to idle at once and
        // the partial frame never completes.
        l0 = lastTotal; g0 = goodTotal; bd0 = badTotal;
        sendFrame(64, 0, -1, -1, 20, 0, sfdCyc, eCyc);
        #1;
        checkResetOutputs("midFrameReset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midFrameReset_tlast", lastTotal - l0, 0);
        checkOutput("midFrameReset_stats", (goodTotal - g0) + (badTotal - bd0), 0);
        b0 = beatTotal; g0 = goodTotal; bd0 = badTotal; t0 = tuserTotal;
        sendFrame(64, 0, -1, -1, -1, 12, sfdCyc, eCyc);
        checkOutput("afterReset_beats", beatTotal - b0, 60);
        checkOutput("afterReset_good", goodTotal - g0, 1);
        checkOutput("afterReset_bad", badTotal - bd0, 0);
        checkOutput("afterReset_tuser", tuserTotal - t0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame.md
# eth_rx_frame

GMII receive framer for the Ethernet RX path. Strips preamble/SFD from the PHY byte stream and feeds frame bytes (including FCS) to the downstream CRC32 checker, re-initialising it per frame. It consumes that checker's `crc_ok`, strips the 4 FCS bytes and emits payload as a streaming byte interface with end-of-frame and error flags. No backpressure: GMII cannot stall.

## Interface
- `MIN_LEN`, 64: minimum frame length in bytes (DA through FCS); shorter is a runt error.
- `MAX_LEN`, 1518: maximum frame length in bytes (DA through FCS); longer is an oversize error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rx_dv` in 1: GMII data valid.
- `rx_er` in 1: GMII receive error.
- `rxd` in 8: GMII data.
- `crc_valid` out 1: byte strobe to CRC checker (`data_valid`).
- `crc_data` out 8: byte to CRC checker (`data_in`).
- `crc_clr_n` out 1: active-low checker init pulse; top level ANDs it with `rst_n`.
- `crc_ok` in 1: checker result.
- `m_tdata` out 8: payload byte.
- `m_tvalid` out 1: payload beat valid.
- `m_tlast` out 1: last payload beat of frame.
- `m_tuser` out 1: frame bad; meaningful only with `m_tlast`.
- `stat_good` out 1: one-cycle pulse with a good `m_tlast`.
- `stat_bad` out 1: one-cycle pulse with a bad `m_tlast` or a silently dropped frame.

## Operation
- Stage 0 registers `rx_dv`, `rx_er`, `rxd` into `_q`. The FSM operates on `_q`.
- FSM states and transitions:
  - IDLE: `dv_q`=1 and `rxd_q`=0x55 → PREAMBLE. `dv_q`=1 and any other byte → DROP.
  - PREAMBLE: 0x55 → stay. 0xD5 → DATA, with `crc_clr_n` low for exactly one cycle. Other byte, or `dv_q`=0 → DROP (or IDLE if `dv_q`=0).
  - DATA: each `dv_q` byte drives `crc_valid`=1 and `crc_data`=`rxd_q` (registered), increments the length counter, and enters the strip line. `dv_q`=0 → CHECK.
  - CHECK: samples `crc_ok`, emits end of frame, → IDLE unconditionally.
  - DROP: no outputs. → IDLE when `dv_q`=0.
- Length counter: 11 bits, saturates at 2047, cleared on SFD.
- Error flag is sticky for the frame; it is set by any of:
  - `er_q`=1 in DATA;
  - length > `MAX_LEN`;
  - at CHECK: length < `MIN_LEN` or `crc_ok`=0.
- FCS strip line, 5 bytes deep:
  - A byte is emitted (`m_tvalid`=1, `m_tlast`=0) when a 6th byte arrives behind it.
  - At CHECK, the oldest held byte is emitted with `m_tlast`=1 and `m_tuser`=error. The remaining 4 bytes are the FCS and are discarded.
- Frames with length ≤4 emit no beats; CHECK pulses `stat_bad` only.
- Frame with length exactly 5: single beat, with `m_tlast`=1.
- `dv_q` high during CHECK (IPG violation): that byte is lost, and the next frame needs a fresh preamble.
- Reset mid-frame: all state is cleared, no `m_tlast` is produced, and the partial frame is never completed downstream.

## Timing
- Reset values:
  - 0: `crc_valid`, `crc_data`, `m_tdata`, `m_tvalid`, `m_tlast`, `m_tuser`, `stat_good`, `stat_bad`.
  - 1: `crc_clr_n`.
  - FSM = IDLE.
- SFD on pins at cycle t:
  - `rxd_q` holds it at t+1.
  - `crc_clr_n`=0 during t+2.
  - First DA byte on `crc_valid` at t+3.
- Byte on pins at cycle n appears on `crc_data` at n+2.
- Last FCS byte on pins at cycle e:
  - `crc_valid` at e+2.
  - `dv_q`=0 at e+2.
  - CHECK at e+3, where `crc_ok` is valid.
  - `m_tlast`, `m_tuser`, `stat_*` registered, visible at e+4.
- All `m_*` and `stat_*` outputs are registered. At most one beat per cycle.

## Structure
- Shared package `eth_pkg` holds:
  - state enum `rx_state_t` (IDLE, PREAMBLE, DATA, CHECK, DROP);
  - `PREAMBLE_BYTE`=8'h55, `SFD_BYTE`=8'hD5;
  - `FCS_LEN`=4;
  - `LEN_W`=11.
- One sub-module, `eth_rx_fcs_strip`: 5-byte shift register with occupancy count, `push`/`flush`/`clear` inputs, and beat/last outputs.
- The CRC checker is not instantiated here; it is wired at the RX top level.

## Test plan
- 7×0x55, 0xD5, 60-byte payload, correct FCS:
  - 60 beats, `m_tlast` on byte 60, `m_tuser`=0, `stat_good` pulse.
  - `crc_clr_n` low once, 2 cycles after SFD.
- Same frame with the last FCS byte XOR 0x01 → 60 beats, `m_tuser`=1, `stat_bad`.
- 40-byte frame with valid FCS → 36 beats, `m_tuser`=1 (runt). 1600-byte frame → `m_tuser`=1 (oversize).
- `rx_er` pulsed on payload byte 10 → frame completes, `m_tuser`=1. Preamble byte 0x54 → DROP, zero beats until `rx_dv` falls.
- Two good 64-byte frames with 12-byte IPG → both `m_tuser`=0, proving the checker is re-initialised per frame.
- `rst_n` asserted at payload byte 20 → outputs at reset values within the cycle. Next good frame → clean `stat_good`.
